rr_arbiter_8: RTL and testbench

- Eight-requester arbiter that shares one resource, with fairness and a bounded hold time.
- Takes a request vector, registers a one-hot grant and the matching 3-bit binary index, and tracks how long each grant is held.
- A grant ends when its requester releases it or, if other requesters are waiting, when a hold-time limit expires.
- Sits between the requester blocks and the shared resource in the lab datapath.

---
 rtl/rr_arbiter_8.sv | 147 ++++++++++++++
 tb/tb_rr_arbiter_8.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester arbiter for one shared resource with a bounded hold time.
// Grant, index and expiry pulse are registered. A contended grant is preempted after
// MAX_HOLD cycles; MAX_HOLD = 0 disables the timeout.
// Optional macro RR_FAIR_EN: when defined, winners are chosen round-robin from a rotation
// pointer; when undefined, the highest-index effective request wins and no pointer exists.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam bit TimeoutEn = (MAX_HOLD != 0);
  // Last count value of a grant; the timeout fires on the edge that sees it.
  localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [7:0]        gnt_q, gnt_d;
  logic [2:0]        idx_q, idx_d;
  logic              exp_q, exp_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        mask_q, mask_d;

  logic [7:0]        eff;
  logic              win_found;
  logic [2:0]        win_idx;
  logic              timeout;

  // A requester preempted by timeout sits out exactly one arbitration.
  assign eff = req & ~mask_q;

`ifdef RR_FAIR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cand;

  // Round-robin search: first effective request at or after ptr, wrapping 7 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && eff[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`else
  // Fixed priority: the highest set index of eff wins.
  always_comb begin
    win_found = |eff;
    win_idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (eff[k]) begin
        win_idx = 3'(k);
      end
    end
  end
`endif

  assign timeout = TimeoutEn && (hold_q == HoldLast) && ((req & ~gnt_q) != 8'h00);

  // Next-state logic for the IDLE/BUSY controller and its datapath registers.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    exp_d   = 1'b0;
    hold_d  = hold_q;
    mask_d  = mask_q;
`ifdef RR_FAIR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      StIdle: begin
        mask_d = '0;
        if (win_found) begin
          gnt_d   = 8'h01 << win_idx;
          idx_d   = win_idx;
          hold_d  = '0;
          state_d = StBusy;
`ifdef RR_FAIR_EN
          ptr_d   = win_idx + 3'd1;
`endif
        end
      end
      StBusy: begin
        if (!req[idx_q]) begin
          // Release takes priority over a simultaneous timeout.
          gnt_d   = '0;
          state_d = StIdle;
        end else if (timeout) begin
          gnt_d   = '0;
          exp_d   = 1'b1;
          mask_d  = gnt_q;
          state_d = StIdle;
        end else if (TimeoutEn && (hold_q != HoldLast)) begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      exp_q   <= 1'b0;
      hold_q  <= '0;
      mask_q  <= '0;
`ifdef RR_FAIR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
`ifdef RR_FAIR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign expired   = exp_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for rr_arbiter_8. Two instances are used, one with
// MAX_HOLD=4 (timeout scenarios) and one with the default MAX_HOLD=16. Each stimulus cycle
// pushes the outputs expected after the coming rising edge; the monitor pops and compares.
module tb_rr_arbiter_8;

  typedef struct packed {
    logic       sel;  // 0: MAX_HOLD=4 instance, 1: MAX_HOLD=16 instance
    logic       v;
    logic [2:0] idx;
    logic       ex;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req4 = 8'h00;
  logic [7:0] req16 = 8'h00;

  logic [7:0] gnt4, gnt16;
  logic [2:0] idx4, idx16;
  logic       v4, v16, ex4, ex16;

  exp_t        sb_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(3)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4),
    .gnt       (gnt4),
    .gnt_idx   (idx4),
    .gnt_valid (v4),
    .expired   (ex4)
  );

  rr_arbiter_8 u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .req       (req16),
    .gnt       (gnt16),
    .gnt_idx   (idx16),
    .gnt_valid (v16),
    .expired   (ex16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what must appear after the next rising edge.
  task automatic cyc(input logic sel, input logic rs, input logic [7:0] r,
                     input logic v, input logic [2:0] idx, input logic ex);
    exp_t e;
    @(negedge clk);
    rst = rs;
    if (sel) begin
      req16 = r;
      req4  = 8'h00;
    end else begin
      req4  = r;
      req16 = 8'h00;
    end
    e.sel = sel;
    e.v   = v;
    e.idx = idx;
    e.ex  = ex;
    sb_q.push_back(e);
  endtask

  // Expected grant order under sustained contention on the MAX_HOLD=4 instance.
  function automatic logic [2:0] order_of(input int k);
`ifdef RR_FAIR_EN
    return 3'(k % 8);
`else
    return ((k % 2) == 1) ? 3'd6 : 3'd7;
`endif
  endfunction

  always @(posedge clk) begin : mon
    exp_t       e;
    logic [7:0] g;
    logic [2:0] gi;
    logic       gv;
    logic       gx;
    logic [7:0] eg;
    #1;
    if (sb_q.size() != 0) begin
      e  = sb_q.pop_front();
      g  = e.sel ? gnt16 : gnt4;
      gi = e.sel ? idx16 : idx4;
      gv = e.sel ? v16 : v4;
      gx = e.sel ? ex16 : ex4;
      eg = e.v ? (8'h01 << e.idx) : 8'h00;
      check_eq("gnt", 32'(g), 32'(eg));
      check_eq("gnt_valid", 32'(gv), 32'(e.v));
      check_eq("expired", 32'(gx), 32'(e.ex));
      if (e.v) check_eq("gnt_idx", 32'(gi), 32'(e.idx));
    end
  end

  initial begin
    logic [7:0] r;
    logic [2:0] first, second, w;
    int         n;

    // Reset, then a single requester on index 2.
    cyc(1, 1, 8'h00, 0, 0, 0);
    cyc(1, 1, 8'h00, 0, 0, 0);
    cyc(1, 0, 8'h04, 1, 2, 0);
    repeat (2) cyc(1, 0, 8'h04, 1, 2, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);

    // Two requesters, index 5 wins in either mode (pointer sits at 3).
    cyc(1, 0, 8'h24, 1, 5, 0);
    cyc(1, 0, 8'h24, 1, 5, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);

    // Release-driven hand-over between requesters 0 and 7.
`ifdef RR_FAIR_EN
    first = 3'd0; second = 3'd7;
`else
    first = 3'd7; second = 3'd0;
`endif
    cyc(1, 1, 8'h00, 0, 0, 0);
    r = 8'h81;
    repeat (3) cyc(1, 0, r, 1, first, 0);
    r = 8'h81 & ~(8'h01 << first);
    cyc(1, 0, r, 0, 0, 0);
    cyc(1, 0, r, 1, second, 0);
    r = 8'h81;
    cyc(1, 0, r, 1, second, 0);
    r = 8'h81 & ~(8'h01 << second);
    cyc(1, 0, r, 0, 0, 0);
    cyc(1, 0, r, 1, first, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);

    // Timeout rotation: each grant visible 4 cycles, then an expired gap cycle.
    cyc(0, 1, 8'h00, 0, 0, 0);
`ifdef RR_FAIR_EN
    r = 8'hFF; n = 9;
`else
    r = 8'hC0; n = 4;
`endif
    for (int k = 0; k < n; k++) begin
      w = order_of(k);
      repeat (4) cyc(0, 0, r, 1, w, 0);
      cyc(0, 0, r, 0, 0, 1);
    end
    cyc(0, 0, 8'h00, 0, 0, 0);

    // Release on the timeout edge wins; then the hold count restarts for the next grant.
`ifdef RR_FAIR_EN
    first = 3'd0; second = 3'd1;
`else
    first = 3'd1; second = 3'd0;
`endif
    cyc(0, 1, 8'h00, 0, 0, 0);
    r = 8'h03;
    repeat (4) cyc(0, 0, r, 1, first, 0);
    r = 8'h03 & ~(8'h01 << first);
    cyc(0, 0, r, 0, 0, 0);
    cyc(0, 0, r, 1, second, 0);
    repeat (3) cyc(0, 0, 8'h03, 1, second, 0);
    cyc(0, 0, 8'h03, 0, 0, 1);
    cyc(0, 0, 8'h03, 1, first, 0);
    cyc(0, 0, 8'h00, 0, 0, 0);

    // Uncontended grant lasts indefinitely; a late competitor preempts at once.
    cyc(1, 1, 8'h00, 0, 0, 0);
    repeat (40) cyc(1, 0, 8'h10, 1, 4, 0);
    cyc(1, 0, 8'h12, 0, 0, 1);
    cyc(1, 0, 8'h12, 1, 1, 0);
    cyc(1, 0, 8'h10, 0, 0, 0);
    cyc(1, 0, 8'h10, 1, 4, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);

    // Reset mid-grant drops the grant with no expiry, and clears the pointer.
    cyc(1, 1, 8'h00, 0, 0, 0);
    cyc(1, 0, 8'h08, 1, 3, 0);
    cyc(1, 0, 8'h08, 1, 3, 0);
    cyc(1, 1, 8'h08, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
`ifdef RR_FAIR_EN
    cyc(1, 0, 8'h0C, 1, 2, 0);
`else
    cyc(1, 0, 8'h0C, 1, 3, 0);
`endif
    cyc(1, 0, 8'h00, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
